// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver: synchronised, deglitched frame decoder
// with E0/F0 prefix folding and a show-ahead key FIFO.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 10000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd_en,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       fifo_full,
    output logic       overflow,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } entry_t;

    logic clk_s1, clk_s2;
    logic dat_s1, dat_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    logic           fclk;
    logic [FCW-1:0] fcnt;
    logic           strobe;

    // fcnt counts consecutive samples disagreeing with the filtered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fclk   <= 1'b1;
            fcnt   <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 != fclk) begin
                if (fcnt == FCW'(FILTER_LEN - 1)) begin
                    fclk   <= clk_s2;
                    fcnt   <= '0;
                    strobe <= ~clk_s2;
                end else begin
                    fcnt <= fcnt + FCW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    state_t         state, state_n;
    logic [2:0]     bcnt, bcnt_n;
    logic [7:0]     sh, sh_n;
    logic           par, par_n;
    logic [TCW-1:0] tcnt;
    logic           brk_f, brk_n;
    logic           ext_f, ext_n;
    logic           tmo, acc, perr, ferr;

    assign tmo = (state != IDLE) && !strobe &&
                 (tcnt == TCW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        sh_n    = sh;
        par_n   = par;
        acc     = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (tmo) begin
            state_n = IDLE;
            ferr    = 1'b1;
        end else if (strobe) begin
            unique case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n = DATA;
                        bcnt_n  = 3'd0;
                    end
                end
                DATA: begin
                    sh_n   = {dat_s2, sh[7:1]};
                    bcnt_n = bcnt + 3'd1;
                    if (bcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!dat_s2) ferr = 1'b1;
                    else if (^{sh, par}) acc = 1'b1;
                    else perr = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Strobe counts as cycle 1 so the abort lands TIMEOUT_CYC cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bcnt  <= '0;
            sh    <= '0;
            par   <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            sh    <= sh_n;
            par   <= par_n;
            if (strobe) tcnt <= TCW'(1);
            else if (state == IDLE || tmo) tcnt <= '0;
            else tcnt <= tcnt + TCW'(1);
        end
    end

    logic         is_e0, is_f0;
    logic         push, pop, wr, ovf;
    logic [AW:0]  wptr, rptr, used;
    logic         empty, full;
    entry_t       mem [FIFO_DEPTH];
    entry_t       head;

    assign is_e0 = (sh == 8'hE0);
    assign is_f0 = (sh == 8'hF0);
    assign push  = acc && !is_e0 && !is_f0;
    assign used  = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (used == (AW+1)'(FIFO_DEPTH));
    assign pop   = rd_en && !empty;
    assign wr    = push && (!full || pop);
    assign ovf   = push && full && !pop;

    always_comb begin
        brk_n = brk_f;
        ext_n = ext_f;
        unique case (1'b1)
            ferr, perr, push: begin
                brk_n = 1'b0;
                ext_n = 1'b0;
            end
            acc && is_e0: ext_n = 1'b1;
            acc && is_f0: brk_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_f      <= 1'b0;
            ext_f      <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            brk_f      <= brk_n;
            ext_f      <= ext_n;
            overflow   <= ovf;
            parity_err <= perr;
            frame_err  <= ferr;
            if (wr) begin
                mem[wptr[AW-1:0]] <= '{code: sh, brk: brk_f, ext: ext_f};
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    assign head       = mem[rptr[AW-1:0]];
    assign code_valid = !empty;
    assign code       = empty ? 8'h00 : head.code;
    assign code_break = !empty && head.brk;
    assign code_ext   = !empty && head.ext;
    assign fifo_full  = full;

endmodule
